// File: rtl/useq_portio.sv
// rtl/useq_portio.sv - latched input port, FIFO to output port, edge-triggered interrupt requests
// Optional feature macro: USEQ_PORTIO_VEC_EN (per-bit vectors and per-bit acknowledge)
module useq_portio #(
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ISR_BASE   = 8'hF0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             i_port,
  input  logic                          write_fifo,
  input  logic                          read_fifo,
  input  logic                          ovf_clr,
  input  logic [DATA_W-1:0]             int_mask,
  input  logic                          int_en,
  input  logic                          int_ack,
  output logic [DATA_W-1:0]             l_port,
  output logic [DATA_W-1:0]             o_port,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          int_req,
  output logic [7:0]                    int_vec
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] l_port_q, l_port_d, o_port_q, o_port_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] pend_set, pend_clr;
  logic              update_l, is_empty, is_full, push_ok, pop_ok, ovf_set, ack_ok;

`ifdef USEQ_PORTIO_VEC_EN
  logic [7:0]        sel_idx;

  // Lowest-numbered pending bit wins; scan from the top so bit 0 overrides
  always_comb begin
    sel_idx = 8'd0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 8'(i);
    end
  end
`endif

  // FIFO datapath, port latch and overflow tracking
  always_comb begin
    update_l = !read_fifo && !write_fifo;
    l_port_d = update_l ? i_port : l_port_q;
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push_ok  = write_fifo && (!is_full || read_fifo);
    pop_ok   = read_fifo && !is_empty;
    ovf_set  = write_fifo && is_full && !read_fifo;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = l_port_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);

    o_port_d = o_port_q;
    if (read_fifo) o_port_d = pop_ok ? mem_q[rd_ptr_q] : '0;

    overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  // Rising-edge capture into pending bits and acknowledge clearing
  always_comb begin
    pend_set = update_l ? (i_port & ~l_port_q & int_mask) : '0;
    ack_ok   = int_ack && int_req;
`ifdef USEQ_PORTIO_VEC_EN
    pend_clr = ack_ok ? (DATA_W'(1) << sel_idx) : '0;
    int_vec  = ISR_BASE + (sel_idx << 1);
`else
    pend_clr = ack_ok ? '1 : '0;
    int_vec  = ISR_BASE;
`endif
    // A fresh edge in the acknowledge cycle keeps its bit set
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // State registers; reset overrides any push/pop in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      l_port_q   <= '0;
      o_port_q   <= '0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      l_port_q   <= l_port_d;
      o_port_q   <= o_port_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
    end
  end

  assign l_port     = l_port_q;
  assign o_port     = o_port_q;
  assign fifo_count = count_q;
  assign fifo_empty = is_empty;
  assign fifo_full  = is_full;
  assign overflow   = overflow_q;
  assign int_req    = int_en && (pending_q != '0);

endmodule

// File: doc/useq_portio.md
USEQ_PORTIO -- requirements
Module: useq_portio

Interface
REQ-001 SHALL have parameter DATA_W, default 8, port/FIFO data width (legal 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter ISR_BASE, default 8'hF0, base interrupt vector.
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have ports: i_port  input  DATA_W  external input port.
REQ-007 SHALL have ports: write_fifo  input  1  push latched port value.
REQ-008 SHALL have ports: read_fifo  input  1  pop head to o_port.
REQ-009 SHALL have ports: ovf_clr  input  1  clear overflow flag.
REQ-010 SHALL have ports: int_mask  input  DATA_W  per-bit edge-interrupt enable.
REQ-011 SHALL have ports: int_en  input  1  global interrupt enable from sequencer.
REQ-012 SHALL have ports: int_ack  input  1  one-cycle acknowledge of current vector.
REQ-013 SHALL have ports: l_port  output  DATA_W  registered latched port value.
REQ-014 SHALL have ports: o_port  output  DATA_W  registered popped data.
REQ-015 SHALL have ports: fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy 0..FIFO_DEPTH.
REQ-016 SHALL have ports: fifo_empty, fifo_full, overflow  output  1 each  status.
REQ-017 SHALL have ports: int_req  output  1; int_vec  output  8  interrupt request/vector.

Function
REQ-018 l_port SHALL load i_port each cycle in which neither read_fifo nor write_fifo is high; otherwise hold.
REQ-019 Push SHALL store current l_port at write pointer, advance pointer mod FIFO_DEPTH, count+1; all FIFO_DEPTH entries usable.
REQ-020 Pop SHALL register head into o_port next cycle, advance read pointer mod FIFO_DEPTH, count-1.
REQ-021 Pop when empty SHALL set o_port to 0, pointers/count unchanged.
REQ-022 Push when full without pop SHALL drop data, leave FIFO unchanged, set overflow.
REQ-023 Simultaneous push+pop SHALL both execute; non-empty: count unchanged; empty: o_port=0, push stored, count=1; full: both execute, no overflow.
REQ-024 fifo_empty SHALL be (count==0), fifo_full (count==FIFO_DEPTH), combinational from count.
REQ-025 overflow SHALL be sticky until ovf_clr; set condition SHALL win over ovf_clr in same cycle.
REQ-026 Edge detect: pending[i] SHALL set when i_port[i]=1, l_port[i]=0, int_mask[i]=1, sampled only in cycles where l_port updates.
REQ-027 int_req SHALL equal int_en AND (pending != 0), combinational.
REQ-028 Selected index SHALL be lowest-numbered set pending bit (bit 0 highest priority).
REQ-029 int_ack with int_req high SHALL clear selected pending bit; a new edge on same bit in same cycle SHALL win (bit stays set).
REQ-030 int_ack with int_req low SHALL have no effect.
REQ-031 Pending bits SHALL persist while int_en=0 or masked after setting; mask changes SHALL not clear pending.

Reset
REQ-032 rst SHALL zero pointers, count, FIFO contents, l_port, o_port, overflow, pending; int_req=0, int_vec=ISR_BASE.
REQ-033 rst SHALL take priority over all other inputs in the same cycle, including mid-push/pop.

Configuration
REQ-034 Macro USEQ_PORTIO_VEC_EN defined: int_vec SHALL be (ISR_BASE + 2*index) mod 256; int_ack clears only selected bit.
REQ-035 USEQ_PORTIO_VEC_EN undefined: int_vec SHALL be constant ISR_BASE; int_ack SHALL clear all pending bits.

Verification (DATA_W=8, FIFO_DEPTH=4, VEC_EN defined)
REQ-036 i_port=11,22,33,44,55 each latched then pushed 5 times -> count 4, full=1, overflow=1; 4 pops -> o_port 11,22,33,44, empty=1; 5th pop -> o_port 00.
REQ-037 Count=2, push+pop same cycle -> count stays 2, o_port=head; empty with push+pop -> o_port 00, count 1.
REQ-038 int_mask=0x0A, int_en=1, i_port 00->0A -> pending 0x0A, int_vec F2; int_ack -> int_vec F6; int_ack -> int_req 0.
REQ-039 int_en=0, rising edge bit 3 masked on -> int_req 0; int_en->1 -> int_req 1, int_vec F6.
REQ-040 overflow set then ovf_clr with simultaneous overflowing push -> overflow stays 1; ovf_clr alone -> 0.
REQ-041 rst during push with count 3 -> next cycle count 0, o_port 00, int_vec F0, overflow 0.
